// File: rtl/sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// sram_access_arbiter
//
// Purpose:
//   Arbitrates ownership of the single external SRAM port between
//   NUM_CLIENTS requesters. Only one client owns the port at a time. A grant
//   ends when the owner drops Req, or when it stays idle for TIMEOUT_CYCLES.
//   Between grants, the read-only default client (the display reader) drives
//   the address and data lines, and SRAM_we_n is held high.
//
// Optional feature (compile-time macro):
//   SRAM_ARB_ROUND_ROBIN_EN
//     Defined     : round-robin. The winner is the first eligible index after
//                   the last granted index, wrapping around.
//     Not defined : fixed priority. The lowest eligible index wins.
//
// Ports:
//   Clock             in   system clock
//   Resetn            in   synchronous, active-low reset
//   Req               in   per-client ownership request (level)
//   Activity          in   per-client busy pulse; restarts the idle timer
//   Client_address    in   packed addresses, client i at [i*ADDR_W +: ADDR_W]
//   Client_write_data in   packed write data, client i at [i*DATA_W +: DATA_W]
//   Client_we_n       in   per-client write enable, active-low
//   SRAM_address      out  address muxed from the current owner
//   SRAM_write_data   out  write data muxed from the current owner
//   SRAM_we_n         out  owner's we_n while granted, otherwise 1
//   Grant             out  one-hot registered grant; all-zero while idle
//   Owner_id          out  index currently muxed onto the SRAM port
//   Busy              out  high while a grant or its release cycle is active
//   Timeout_pulse     out  one-cycle pulse when a grant is force-released
// ---------------------------------------------------------------------------
module sram_access_arbiter #(
    parameter int NUM_CLIENTS    = 4,
    parameter int ADDR_W         = 18,
    parameter int DATA_W         = 16,
    parameter int DEFAULT_CLIENT = 0,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                            Clock,
    input  logic                            Resetn,
    input  logic [NUM_CLIENTS-1:0]          Req,
    input  logic [NUM_CLIENTS-1:0]          Activity,
    input  logic [NUM_CLIENTS*ADDR_W-1:0]   Client_address,
    input  logic [NUM_CLIENTS*DATA_W-1:0]   Client_write_data,
    input  logic [NUM_CLIENTS-1:0]          Client_we_n,
    output logic [ADDR_W-1:0]               SRAM_address,
    output logic [DATA_W-1:0]               SRAM_write_data,
    output logic                            SRAM_we_n,
    output logic [NUM_CLIENTS-1:0]          Grant,
    output logic [$clog2(NUM_CLIENTS)-1:0]  Owner_id,
    output logic                            Busy,
    output logic                            Timeout_pulse
);

    localparam int OW = $clog2(NUM_CLIENTS);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    localparam logic [OW-1:0]          DEF_ID     = OW'(DEFAULT_CLIENT);
    localparam logic [NUM_CLIENTS-1:0] DEF_BIT    = NUM_CLIENTS'(1) << DEFAULT_CLIENT;
    localparam logic [TW-1:0]          TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic [NUM_CLIENTS-1:0] mask_q,  mask_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   pulse_q, pulse_d;

    logic [NUM_CLIENTS-1:0] eligible;
    logic                   found;
    logic [OW-1:0]          winner;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic [OW-1:0]          last_q, last_d;
    logic [OW-1:0]          idx;
`endif

    // Winner selection. The default client can never be granted, and a
    // client that timed out stays masked until it drops Req.
    always_comb begin
        eligible = Req & ~mask_q & ~DEF_BIT;
        found    = 1'b0;
        winner   = DEF_ID;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        idx      = '0;
        // Search starts one index after the last winner. k = NUM_CLIENTS
        // revisits the last winner itself, so it can win when alone.
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            idx = OW'((int'(last_q) + k) % NUM_CLIENTS);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
`else
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (!found && eligible[i]) begin
                found  = 1'b1;
                winner = OW'(i);
            end
        end
`endif
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        // A mask bit clears in any cycle where that client's Req is low.
        mask_d  = mask_q & Req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_GRANT;
                    grant_d = NUM_CLIENTS'(1) << winner;
                    owner_d = winner;
                    timer_d = '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_d  = winner;
`endif
                end
            end

            S_GRANT: begin
                // Timeout is checked first. A Req drop in the same cycle still
                // counts as a timeout: the pulse fires and the mask bit is set.
                if (timer_q == TIMER_LAST) begin
                    state_d         = S_RELEASE;
                    grant_d         = '0;
                    owner_d         = DEF_ID;
                    timer_d         = '0;
                    pulse_d         = 1'b1;
                    mask_d[owner_q] = 1'b1;
                end else if (!Req[owner_q]) begin
                    state_d = S_RELEASE;
                    grant_d = '0;
                    owner_d = DEF_ID;
                    timer_d = '0;
                end else if (Activity[owner_q] || !Client_we_n[owner_q]) begin
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            // Single turnaround cycle. No grant is issued from here.
            S_RELEASE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                owner_d = DEF_ID;
                timer_d = '0;
            end
        endcase

        mask_d = mask_d & ~DEF_BIT;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            mask_q  <= '0;
            owner_q <= DEF_ID;
            timer_q <= '0;
            pulse_q <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            // Starting at the top index makes the first search begin at index 0.
            last_q  <= OW'(NUM_CLIENTS - 1);
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            mask_q  <= mask_d;
            owner_q <= owner_d;
            timer_q <= timer_d;
            pulse_q <= pulse_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // The SRAM port mux is combinational from the registered owner. The
    // default client is read-only, so we_n is forced high outside S_GRANT.
    assign SRAM_address    = Client_address[owner_q*ADDR_W +: ADDR_W];
    assign SRAM_write_data = Client_write_data[owner_q*DATA_W +: DATA_W];
    assign SRAM_we_n       = (state_q == S_GRANT) ? Client_we_n[owner_q] : 1'b1;

    assign Grant           = grant_q;
    assign Owner_id        = owner_q;
    assign Busy            = (state_q != S_IDLE);
    assign Timeout_pulse   = pulse_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_access_arbiter
//
// Directed testbench for sram_access_arbiter. Configuration: 4 clients,
// 18-bit addresses, 16-bit data, default client 0, TIMEOUT_CYCLES = 16.
// The expected round-robin grant order depends on SRAM_ARB_ROUND_ROBIN_EN.
// ---------------------------------------------------------------------------
module tb_sram_access_arbiter;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int DW = 16;

    logic            Clock;
    logic            Resetn;
    logic [N-1:0]    Req;
    logic [N-1:0]    Activity;
    logic [N*AW-1:0] Client_address;
    logic [N*DW-1:0] Client_write_data;
    logic [N-1:0]    Client_we_n;
    logic [AW-1:0]   SRAM_address;
    logic [DW-1:0]   SRAM_write_data;
    logic            SRAM_we_n;
    logic [N-1:0]    Grant;
    logic [1:0]      Owner_id;
    logic            Busy;
    logic            Timeout_pulse;

    int total  = 0;
    int passed = 0;

    sram_access_arbiter #(
        .NUM_CLIENTS   (N),
        .ADDR_W        (AW),
        .DATA_W        (DW),
        .DEFAULT_CLIENT(0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .Clock            (Clock),
        .Resetn           (Resetn),
        .Req              (Req),
        .Activity         (Activity),
        .Client_address   (Client_address),
        .Client_write_data(Client_write_data),
        .Client_we_n      (Client_we_n),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_we_n        (SRAM_we_n),
        .Grant            (Grant),
        .Owner_id         (Owner_id),
        .Busy             (Busy),
        .Timeout_pulse    (Timeout_pulse)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One clock edge; inputs and outputs then settle 1 time unit after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    int            pulses_seen;
    int            owner_exp;
    logic [1:0]    rr_order [4];

    initial begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        rr_order[0] = 2'd1; rr_order[1] = 2'd2; rr_order[2] = 2'd3; rr_order[3] = 2'd1;
`else
        rr_order[0] = 2'd1; rr_order[1] = 2'd1; rr_order[2] = 2'd1; rr_order[3] = 2'd1;
`endif

        Resetn            = 1'b0;
        Req               = 4'b1110;
        Activity          = '0;
        Client_address    = '0;
        Client_write_data = '0;
        Client_we_n       = 4'b1111;
        #1;

        // ---- reset held for two cycles while requests are pending ----
        step();
        step();
        check("rst_grant",  32'(Grant), 32'h0);
        check("rst_owner",  32'(Owner_id), 32'h0);
        check("rst_we_n",   32'(SRAM_we_n), 32'h1);
        check("rst_busy",   32'(Busy), 32'h0);
        check("rst_pulse",  32'(Timeout_pulse), 32'h0);

        Resetn = 1'b1;
        step();
        check("post_rst_grant", 32'(Grant), 32'h2);
        check("post_rst_owner", 32'(Owner_id), 32'h1);
        check("post_rst_busy",  32'(Busy), 32'h1);

        // ---- output mux: client 1 owns the port and writes ----
        Client_address[1*AW +: AW]    = 18'h2A5F0;
        Client_write_data[1*DW +: DW] = 16'hBEEF;
        Client_we_n                   = 4'b1101;
        #1;
        check("mux_addr", 32'(SRAM_address), 32'h2A5F0);
        check("mux_data", 32'(SRAM_write_data), 32'hBEEF);
        check("mux_we_n", 32'(SRAM_we_n), 32'h0);

        Client_we_n = 4'b1111;
        Req         = 4'b0000;
        step();
        check("rel1_grant", 32'(Grant), 32'h0);
        check("rel1_busy",  32'(Busy), 32'h1);
        check("rel1_owner", 32'(Owner_id), 32'h0);
        check("rel1_pulse", 32'(Timeout_pulse), 32'h0);
        step();
        check("idle1_busy", 32'(Busy), 32'h0);

        // ---- fixed priority: client 2 beats client 3 ----
        Req = 4'b1100;
        step();
        check("prio_grant2", 32'(Grant), 32'h4);
        Req         = 4'b1000;
        Client_we_n = 4'b0000;
        step();
        check("prio_rel_grant", 32'(Grant), 32'h0);
        check("prio_rel_we_n",  32'(SRAM_we_n), 32'h1);
        check("prio_rel_busy",  32'(Busy), 32'h1);
        Client_we_n = 4'b1111;
        step();
        check("prio_idle_grant", 32'(Grant), 32'h0);
        step();
        check("prio_grant3", 32'(Grant), 32'h8);
        check("prio_owner3", 32'(Owner_id), 32'h3);
        Req = 4'b0000;
        step();
        step();

        // ---- timeout: client 3 holds Req with no activity ----
        Req = 4'b1000;
        step();
        check("to_grant", 32'(Grant), 32'h8);
        for (int i = 0; i < 15; i++) step();
        check("to_before_grant", 32'(Grant), 32'h8);
        check("to_before_pulse", 32'(Timeout_pulse), 32'h0);
        step();
        check("to_pulse", 32'(Timeout_pulse), 32'h1);
        check("to_grant_drop", 32'(Grant), 32'h0);
        step();
        check("to_pulse_end", 32'(Timeout_pulse), 32'h0);
        check("to_idle_busy", 32'(Busy), 32'h0);
        step();
        step();
        check("to_masked", 32'(Grant), 32'h0);
        Req = 4'b0000;
        step();
        Req = 4'b1000;
        step();
        check("to_regrant", 32'(Grant), 32'h8);

        // Activity every 10 cycles keeps the grant alive.
        pulses_seen = 0;
        for (int i = 0; i < 40; i++) begin
            Activity = ((i % 10) == 9) ? 4'b1000 : 4'b0000;
            step();
            if (Timeout_pulse === 1'b1) pulses_seen++;
        end
        Activity = '0;
        check("act_no_pulse", 32'(pulses_seen), 32'h0);
        check("act_grant",    32'(Grant), 32'h8);
        Req = 4'b0000;
        step();
        step();

        // ---- default read path ----
        Client_address[0*AW +: AW] = 18'h01234;
        Client_we_n                = 4'b1110;
        #1;
        check("def_addr", 32'(SRAM_address), 32'h01234);
        check("def_we_n", 32'(SRAM_we_n), 32'h1);
        Req = 4'b0001;
        step();
        check("def_req_grant", 32'(Grant), 32'h0);
        check("def_req_busy",  32'(Busy), 32'h0);
        step();
        check("def_req_grant2", 32'(Grant), 32'h0);
        Req         = 4'b0000;
        Client_we_n = 4'b1111;
        step();

        // ---- arbitration order with repeated short drops ----
        Req = 4'b1110;
        step();
        owner_exp = int'(rr_order[0]);
        check("rr_grant0", 32'(Owner_id), 32'(rr_order[0]));
        for (int k = 1; k < 4; k++) begin
            step();
            step();
            Req[owner_exp] = 1'b0;
            step();
            Req = 4'b1110;
            step();
            step();
            check($sformatf("rr_grant%0d", k), 32'(Grant), 32'(4'b0001 << rr_order[k]));
            owner_exp = int'(rr_order[k]);
        end

        // ---- reset in the middle of a grant ----
        Resetn = 1'b0;
        step();
        check("midrst_grant", 32'(Grant), 32'h0);
        check("midrst_busy",  32'(Busy), 32'h0);
        check("midrst_owner", 32'(Owner_id), 32'h0);
        Resetn = 1'b1;
        Req    = 4'b0000;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
